// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution line feeder: FSM states,
// stride decode and logical-row to physical-slot mapping.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        READY,
        ADVANCE,
        DONE
    } feeder_state_t;

    function automatic logic [1:0] decode_stride(input logic [1:0] code);
        return (code == 2'd2) ? 2'd2 : 2'd1;
    endfunction

    // base is 0..2 and k is at most 2, so one wrap is sufficient
    function automatic logic [1:0] slot_of(input logic [1:0] base, input logic [1:0] k);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, k};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

endpackage

// File: rtl/line_row_bank.sv
// Three physical row slots of IMG_W pixels; one write port and one column
// read that returns logical rows 0..2 relative to a rotating base slot.
module line_row_bank
    import conv_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_W     = 16,
    parameter int COL_W     = $clog2(IMG_W)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [1:0]           wr_slot,
    input  logic [COL_W-1:0]     wr_col,
    input  logic [BIT_DEPTH-1:0] wr_data,
    input  logic [1:0]           rd_base,
    input  logic [COL_W-1:0]     rd_col,
    output logic [BIT_DEPTH-1:0] rd_l1,
    output logic [BIT_DEPTH-1:0] rd_l2,
    output logic [BIT_DEPTH-1:0] rd_l3
);

    logic [BIT_DEPTH-1:0] mem [3][IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_slot][wr_col] <= wr_data;
        end
    end

    always_comb begin
        rd_l1 = mem[slot_of(rd_base, 2'd0)][rd_col];
        rd_l2 = mem[slot_of(rd_base, 2'd1)][rd_col];
        rd_l3 = mem[slot_of(rd_base, 2'd2)][rd_col];
    end

endmodule

// File: rtl/conv_line_feeder.sv
// Streams a row-major feature map as 3-row bands, one column per shift,
// reusing held rows and fetching only the stride new rows between bands.
module conv_line_feeder
    import conv_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_W     = 16,
    parameter int IMG_H     = 16,
    parameter int ADDR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           stride,
    output logic                 src_rd_en,
    output logic [ADDR_W-1:0]    src_addr,
    input  logic [BIT_DEPTH-1:0] src_data,
    input  logic                 shift,
    output logic [BIT_DEPTH-1:0] out_l1,
    output logic [BIT_DEPTH-1:0] out_l2,
    output logic [BIT_DEPTH-1:0] out_l3,
    output logic                 band_ready,
    output logic                 band_last,
    output logic                 done
);

    localparam int COL_W  = $clog2(IMG_W);
    localparam int CNT_W  = $clog2(3 * IMG_W + 1);
    localparam int BAND_W = $clog2(IMG_H);

    localparam logic [CNT_W-1:0]  FILL_N    = CNT_W'(3 * IMG_W);
    localparam logic [CNT_W-1:0]  ADV1_N    = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0]  ADV2_N    = CNT_W'(2 * IMG_W);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(IMG_W - 1);
    localparam logic [BAND_W-1:0] LAST_B_S1 = BAND_W'(IMG_H - 3);
    localparam logic [BAND_W-1:0] LAST_B_S2 = BAND_W'((IMG_H - 3) / 2);

    feeder_state_t state, next_state;

    logic [1:0]           stride_r;
    logic [1:0]           base;
    logic [BAND_W-1:0]    band;
    logic [CNT_W-1:0]     rd_cnt;
    logic [ADDR_W-1:0]    fetch_addr;
    logic [COL_W-1:0]     fetch_col;
    logic [1:0]           fetch_k;
    logic [COL_W-1:0]     col;
    logic                 wr_pend;
    logic [1:0]           wr_slot;
    logic [COL_W-1:0]     wr_col;
    logic [COL_W-1:0]     rd_col;
    logic [BIT_DEPTH-1:0] bank_l1, bank_l2, bank_l3;
    logic [CNT_W-1:0]     fetch_n;
    logic                 fetch_busy, fetch_end, col_last, band_final;

    always_comb begin
        fetch_n    = (state == FILL) ? FILL_N : ((stride_r == 2'd2) ? ADV2_N : ADV1_N);
        fetch_busy = (state == FILL) || (state == ADVANCE);
        fetch_end  = fetch_busy && (rd_cnt == fetch_n);
        col_last   = (col == COL_MAX);
        band_final = (band == ((stride_r == 2'd2) ? LAST_B_S2 : LAST_B_S1));
        // show-ahead: READY reads the column a shift would expose next
        rd_col     = (state == READY) ? col + 1'b1 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FILL;
            FILL:    if (fetch_end) next_state = READY;
            ADVANCE: if (fetch_end) next_state = READY;
            READY:   if (shift && col_last) next_state = band_final ? DONE : ADVANCE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        src_rd_en  = fetch_busy && (rd_cnt != fetch_n);
        band_ready = (state == READY);
        band_last  = (state == READY) && band_final;
        done       = (state == DONE);
    end

    assign src_addr = fetch_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_r   <= '0;
            base       <= '0;
            band       <= '0;
            rd_cnt     <= '0;
            fetch_addr <= '0;
            fetch_col  <= '0;
            fetch_k    <= '0;
            col        <= '0;
            out_l1     <= '0;
            out_l2     <= '0;
            out_l3     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        stride_r   <= decode_stride(stride);
                        base       <= '0;
                        band       <= '0;
                        rd_cnt     <= '0;
                        fetch_addr <= '0;
                        fetch_col  <= '0;
                        fetch_k    <= '0;
                        col        <= '0;
                    end
                end
                FILL, ADVANCE: begin
                    if (src_rd_en) begin
                        rd_cnt     <= rd_cnt + 1'b1;
                        fetch_addr <= fetch_addr + 1'b1;
                        if (fetch_col == COL_MAX) begin
                            fetch_col <= '0;
                            fetch_k   <= fetch_k + 2'd1;
                        end else begin
                            fetch_col <= fetch_col + 1'b1;
                        end
                    end
                    if (fetch_end) begin
                        col    <= '0;
                        out_l1 <= bank_l1;
                        out_l2 <= bank_l2;
                        out_l3 <= bank_l3;
                    end
                end
                READY: begin
                    if (shift) begin
                        if (col_last) begin
                            // rotate base first so new rows land in the freed slots
                            if (!band_final) begin
                                base      <= slot_of(base, stride_r);
                                band      <= band + 1'b1;
                                rd_cnt    <= '0;
                                fetch_col <= '0;
                                fetch_k   <= 2'd3 - stride_r;
                            end
                        end else begin
                            col    <= col + 1'b1;
                            out_l1 <= bank_l1;
                            out_l2 <= bank_l2;
                            out_l3 <= bank_l3;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pend <= 1'b0;
            wr_slot <= '0;
            wr_col  <= '0;
        end else begin
            wr_pend <= src_rd_en;
            wr_slot <= slot_of(base, fetch_k);
            wr_col  <= fetch_col;
        end
    end

    line_row_bank #(
        .BIT_DEPTH (BIT_DEPTH),
        .IMG_W     (IMG_W),
        .COL_W     (COL_W)
    ) u_bank (
        .clk     (clk),
        .wr_en   (wr_pend),
        .wr_slot (wr_slot),
        .wr_col  (wr_col),
        .wr_data (src_data),
        .rd_base (base),
        .rd_col  (rd_col),
        .rd_l1   (bank_l1),
        .rd_l2   (bank_l2),
        .rd_l3   (bank_l3)
    );

endmodule

// File: tb/tb_conv_line_feeder.sv
// Randomized bench for conv_line_feeder: a behavioural model of band/column
// order and source fetch order checks every observed cycle.
module tb_conv_line_feeder;

    localparam int W = 16;
    localparam int H = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] stride = '0;
    logic       shift = 1'b0;
    logic       src_rd_en;
    logic [7:0] src_addr;
    logic [7:0] src_data = '0;
    logic [7:0] out_l1, out_l2, out_l3;
    logic       band_ready, band_last, done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        src_data <= src_rd_en ? mem[src_addr] : 8'($urandom);
    end

    conv_line_feeder #(
        .BIT_DEPTH (8),
        .IMG_W     (W),
        .IMG_H     (H),
        .ADDR_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stride     (stride),
        .src_rd_en  (src_rd_en),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .shift      (shift),
        .out_l1     (out_l1),
        .out_l2     (out_l2),
        .out_l3     (out_l3),
        .band_ready (band_ready),
        .band_last  (band_last),
        .done       (done)
    );

    function automatic logic [7:0] pix(input int r, input int c);
        return mem[r * W + c];
    endfunction

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 256; i++) begin
            mem[i] = rnd ? 8'($urandom) : 8'(i);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        shift = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({src_rd_en, band_ready, band_last, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 0000", {src_rd_en, band_ready, band_last, done});
        end
        vectors++;
        if ({out_l1, out_l2, out_l3, src_addr} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 00000000", {out_l1, out_l2, out_l3, src_addr});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One full map: model predicts fetch addresses, band timing and every column.
    task automatic test_stream(input logic [1:0] stride_code, input int shift_pct,
                               input bit poke_start, input string tag);
        int s, nb, band, col, t, gap, reads, total_reads;
        bit finished, prev_ready;
        int exp_addr[$];
        s = (stride_code == 2'd2) ? 2 : 1;
        nb = (H - 3) / s + 1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++) exp_addr.push_back(r * W + c);
        for (int b = 1; b < nb; b++)
            for (int r = b * s + 3 - s; r <= b * s + 2; r++)
                for (int c = 0; c < W; c++) exp_addr.push_back(r * W + c);
        total_reads = exp_addr.size();
        band = 0; col = 0; t = 0; gap = 0; reads = 0;
        finished = 1'b0; prev_ready = 1'b0;

        stride = stride_code;
        shift = ($urandom_range(99) < shift_pct);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        while (!finished && t < 4000) begin
            if (src_rd_en) begin
                vectors++;
                if (exp_addr.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s extra_read: got addr %0d want no read", tag, src_addr);
                end else begin
                    if (src_addr !== 8'(exp_addr[0])) begin
                        miscompares++;
                        $display("FAIL %s addr: got %0d want %0d", tag, src_addr, exp_addr[0]);
                    end
                    void'(exp_addr.pop_front());
                end
                reads++;
            end
            if (band_ready) begin
                if (!prev_ready) begin
                    vectors++;
                    if (band == 0 && t != 3 * W + 1) begin
                        miscompares++;
                        $display("FAIL %s fill_latency: got %0d want %0d", tag, t, 3 * W + 1);
                    end else if (band > 0 && gap != s * W + 1) begin
                        miscompares++;
                        $display("FAIL %s advance_len band %0d: got %0d want %0d", tag, band, gap, s * W + 1);
                    end
                end
                vectors++;
                if (band >= nb) begin
                    miscompares++;
                    $display("FAIL %s extra_band: got band %0d want at most %0d", tag, band, nb - 1);
                end else if ({out_l1, out_l2, out_l3} !==
                             {pix(band * s, col), pix(band * s + 1, col), pix(band * s + 2, col)}) begin
                    miscompares++;
                    $display("FAIL %s column b%0d c%0d: got %h want %h", tag, band, col,
                             {out_l1, out_l2, out_l3},
                             {pix(band * s, col), pix(band * s + 1, col), pix(band * s + 2, col)});
                end
                vectors++;
                if (band_last !== (band == nb - 1)) begin
                    miscompares++;
                    $display("FAIL %s band_last b%0d: got %b want %b", tag, band, band_last, band == nb - 1);
                end
            end else if (band > 0) begin
                gap++;
                vectors++;
                if ({out_l1, out_l2, out_l3} !== {pix((band - 1) * s, W - 1),
                        pix((band - 1) * s + 1, W - 1), pix((band - 1) * s + 2, W - 1)}) begin
                    miscompares++;
                    $display("FAIL %s hold b%0d: got %h want %h", tag, band, {out_l1, out_l2, out_l3},
                             {pix((band - 1) * s, W - 1), pix((band - 1) * s + 1, W - 1),
                              pix((band - 1) * s + 2, W - 1)});
                end
            end
            if (done) begin
                finished = 1'b1;
                vectors++;
                if (band != nb || exp_addr.size() != 0) begin
                    miscompares++;
                    $display("FAIL %s done_early: got bands %0d reads %0d want %0d %0d",
                             tag, band, reads, nb, total_reads);
                end
            end
            prev_ready = band_ready;

            shift = ($urandom_range(99) < shift_pct);
            start = poke_start && band_ready && ($urandom_range(9) == 0);
            if (band_ready && shift) begin
                col++;
                if (col == W) begin
                    col = 0;
                    band++;
                    gap = 0;
                end
            end
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        shift = 1'b0;

        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL %s timeout: got no done after %0d cycles want done", tag, t);
        end else if ({done, band_ready, src_rd_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s after_done: got %b want 000", tag, {done, band_ready, src_rd_en});
        end
        vectors++;
        if (reads != total_reads) begin
            miscompares++;
            $display("FAIL %s read_count: got %0d want %0d", tag, reads, total_reads);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if ({src_rd_en, band_ready, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s idle: got %b want 000", tag, {src_rd_en, band_ready, done});
        end
    endtask

    task automatic test_reset_mid_fill();
        stride = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (src_rd_en !== 1'b1 || src_addr !== 8'd20) begin
            miscompares++;
            $display("FAIL mid_fill_pre: got en %b addr %0d want 1 20", src_rd_en, src_addr);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({src_rd_en, band_ready, band_last, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_fill_ctrl: got %b want 0000", {src_rd_en, band_ready, band_last, done});
        end
        vectors++;
        if ({out_l1, out_l2, out_l3, src_addr} !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_fill_data: got %h want 00000000", {out_l1, out_l2, out_l3, src_addr});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({src_rd_en, band_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_fill_post: got %b want 00", {src_rd_en, band_ready});
        end
    endtask

    initial begin
        test_reset();
        fill_mem(1'b0);
        test_stream(2'd1, 100, 1'b0, "stride1");
        test_stream(2'd2, 100, 1'b0, "stride2");
        fill_mem(1'b1);
        test_stream(2'd1, 60, 1'b0, "gaps");
        test_stream(2'd3, 70, 1'b0, "stride3");
        test_stream(2'd0, 80, 1'b0, "stride0");
        test_reset_mid_fill();
        test_stream(2'd1, 90, 1'b0, "refill");
        fill_mem(1'b1);
        test_stream(2'd2, 50, 1'b1, "start_in_ready");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
